// File: rtl/efi_pkg.sv
// rtl/efi_pkg.sv - shared engine-controller constants and rpm FSM state encoding
package efi_pkg;
    localparam int CLK_HZ       = 2_000_000;
    localparam int AVG_TEETH    = 32;
    localparam int RPM_DIVIDEND = CLK_HZ * AVG_TEETH;
    localparam int RPM_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } rpm_state_t;
endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - generic unsigned restoring divider, one quotient bit per cycle, MSB first
module seq_divider #(
    parameter int NUM_W = 26,
    parameter int DEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);
    localparam int CW = (DEN_W > NUM_W + 1) ? DEN_W : NUM_W + 1;
    localparam int SW = $clog2(NUM_W);

    logic [NUM_W-1:0] rem;
    logic [NUM_W-1:0] quo;
    logic [DEN_W-1:0] den_q;
    logic [NUM_W:0]   shifted;
    logic             fits;
    logic [SW-1:0]    step;
    logic             run;

    // Remainder never exceeds the dividend prefix, so NUM_W bits hold it; the shifted
    // partial remainder needs one more bit before the compare.
    assign shifted  = {rem, quo[NUM_W-1]};
    assign fits     = CW'(shifted) >= CW'(den_q);
    assign done     = run && (step == '0);
    assign quotient = quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            den_q <= '0;
            step  <= '0;
            run   <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= num;
            den_q <= den;
            step  <= SW'(NUM_W - 1);
            run   <= 1'b1;
        end else if (run) begin
            rem  <= fits ? NUM_W'(CW'(shifted) - CW'(den_q)) : shifted[NUM_W-1:0];
            quo  <= {quo[NUM_W-2:0], fits};
            step <= step - 1'b1;
            if (step == '0)
                run <= 1'b0;
        end
    end
endmodule

// File: rtl/rpm_calc.sv
// rtl/rpm_calc.sv - per-tooth rpm = DIVIDEND / rpm_sum via multi-cycle divide, with stall and sync handling
module rpm_calc #(
    parameter int SUM_W        = 32,
    parameter int RPM_W        = efi_pkg::RPM_W,
    parameter int QW           = 26,
    parameter int DIVIDEND     = efi_pkg::RPM_DIVIDEND,
    parameter int STALL_CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             synced,
    input  logic             trigger,
    input  logic [SUM_W-1:0] rpm_sum,
    output logic [RPM_W-1:0] rpm,
    output logic             rpm_valid,
    output logic             busy,
    output logic             stalled
);
    import efi_pkg::*;

    localparam int SCW = $clog2(STALL_CYCLES + 1);

    rpm_state_t       state, state_next;
    logic [SUM_W-1:0] sum_reg;
    logic             pending;
    logic             div_zero;
    logic             div_start;
    logic             div_last;
    logic [QW-1:0]    quotient;
    logic [RPM_W-1:0] rpm_sat;
    logic [SCW-1:0]   stall_cnt;
    logic             stall_hit;

    seq_divider #(.NUM_W(QW), .DEN_W(SUM_W)) u_div (
        .clk      (clk),
        .rst      (reset),
        .start    (div_start),
        .num      (QW'(DIVIDEND)),
        .den      (sum_reg),
        .done     (div_last),
        .quotient (quotient)
    );

    assign rpm_sat   = (|quotient[QW-1:RPM_W]) ? '1 : quotient[RPM_W-1:0];
    assign busy      = (state == ST_LOAD) || (state == ST_DIV);
    assign stall_hit = synced && !trigger && (stall_cnt == SCW'(STALL_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            ST_IDLE: if ((trigger && synced) || pending) state_next = ST_LOAD;
            ST_LOAD: begin
                // A zero sum means the tooth history is not yet filled: no division
                if (sum_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    div_start  = 1'b1;
                    state_next = ST_DIV;
                end
            end
            ST_DIV:  if (div_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (!synced) begin
            state_next = ST_IDLE;
            div_start  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpm       <= '0;
            rpm_valid <= 1'b0;
            stalled   <= 1'b0;
            pending   <= 1'b0;
            sum_reg   <= '0;
            div_zero  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            rpm_valid <= 1'b0;
            if (!synced) begin
                rpm       <= '0;
                pending   <= 1'b0;
                stalled   <= 1'b0;
                stall_cnt <= '0;
            end else begin
                if (trigger) begin
                    sum_reg   <= rpm_sum;
                    stall_cnt <= '0;
                end else if (stall_cnt != SCW'(STALL_CYCLES)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                // At most one division is queued; later busy triggers only refresh sum_reg
                if (state == ST_IDLE)
                    pending <= 1'b0;
                else if (trigger)
                    pending <= 1'b1;
                if (state == ST_LOAD)
                    div_zero <= (sum_reg == '0);
                if (state == ST_DONE) begin
                    rpm       <= div_zero ? '0 : rpm_sat;
                    rpm_valid <= 1'b1;
                    stalled   <= 1'b0;
                end
                if (stall_hit) begin
                    rpm     <= '0;
                    stalled <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rpm_calc.sv
// tb/tb_rpm_calc.sv - directed self-checking bench for rpm_calc
module tb_rpm_calc;
    localparam int STALL = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        synced;
    logic        trigger;
    logic [31:0] rpm_sum;
    logic [15:0] rpm;
    logic        rpm_valid;
    logic        busy;
    logic        stalled;

    int n_checks = 0;
    int n_errors = 0;

    rpm_calc #(.STALL_CYCLES(STALL)) dut (
        .clk       (clk),
        .reset     (reset),
        .synced    (synced),
        .trigger   (trigger),
        .rpm_sum   (rpm_sum),
        .rpm       (rpm),
        .rpm_valid (rpm_valid),
        .busy      (busy),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!rpm_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // Single trigger; lat is the edge index (edge 1 samples trigger) at which rpm_valid appears
    task automatic run_div(input logic [31:0] s, input logic [15:0] exp, input int lat, input string tag);
        int n;
        synced  = 1'b1;
        trigger = 1'b1;
        rpm_sum = s;
        tick();
        trigger = 1'b0;
        rpm_sum = 32'd7;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(n);
        check({tag, "_lat"}, 32'(n + 1), 32'(lat));
        check({tag, "_rpm"}, 32'(rpm), 32'(exp));
        tick();
        check({tag, "_pulse"}, 32'(rpm_valid), 32'd0);
    endtask

    // First trigger at c=0, extra triggers at c2/c3 while busy; expect results at edges 29 and 58
    task automatic multi(input logic [31:0] s1, input int c2, input logic [31:0] s2,
                         input int c3, input logic [31:0] s3,
                         input logic [15:0] e1, input logic [15:0] e2, input string tag);
        int          nv;
        int          at [2];
        logic [15:0] val [2];
        nv = 0;
        for (int i = 0; i < 2; i++) begin
            at[i]  = 0;
            val[i] = '0;
        end
        for (int c = 0; c < 70; c++) begin
            trigger = (c == 0) || (c == c2) || (c == c3);
            rpm_sum = (c == 0) ? s1 : (c == c2) ? s2 : (c == c3) ? s3 : 32'd5;
            tick();
            if (rpm_valid) begin
                if (nv < 2) begin
                    at[nv]  = c + 1;
                    val[nv] = rpm;
                end
                nv++;
            end
        end
        trigger = 1'b0;
        check({tag, "_nvalid"}, 32'(nv), 32'd2);
        check({tag, "_at0"}, 32'(at[0]), 32'd29);
        check({tag, "_rpm0"}, 32'(val[0]), 32'(e1));
        check({tag, "_at1"}, 32'(at[1]), 32'd58);
        check({tag, "_rpm1"}, 32'(val[1]), 32'(e2));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int c;
        reset   = 1'b1;
        synced  = 1'b0;
        trigger = 1'b0;
        rpm_sum = '0;
        tick();
        tick();
        check("rst_rpm", 32'(rpm), 32'd0);
        check("rst_valid", 32'(rpm_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);
        reset  = 1'b0;
        synced = 1'b1;
        tick();

        run_div(32'd32_000_000, 16'd2, 29, "t1");
        run_div(32'd16_000, 16'd4000, 29, "t2a");
        run_div(32'd0, 16'd0, 3, "t3zero");
        run_div(32'd900, 16'hFFFF, 29, "t2sat");
        run_div(32'd976, 16'hFFFF, 29, "t2sat976");
        run_div(32'd977, 16'd65506, 29, "t2edge977");
        run_div(32'd64_000_000, 16'd1, 29, "t2one");
        run_div(32'd64_000_001, 16'd0, 29, "t2under");
        run_div(32'hFFFF_FFFF, 16'd0, 29, "t2wide");

        multi(32'd16_000, 10, 32'd32_000, -1, 32'd0, 16'd4000, 16'd2000, "t4a");
        multi(32'd16_000, 10, 32'd32_000, 15, 32'd64_000, 16'd4000, 16'd1000, "t4b");

        // Loss of sync mid-division
        trigger = 1'b1;
        rpm_sum = 32'd16_000;
        tick();
        trigger = 1'b0;
        repeat (5) tick();
        check("t5_busy_pre", 32'(busy), 32'd1);
        synced = 1'b0;
        tick();
        check("t5_busy_drop", 32'(busy), 32'd0);
        check("t5_rpm_drop", 32'(rpm), 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) synced = 1'b1;
            tick();
            if (rpm_valid) n++;
        end
        check("t5_no_valid", 32'(n), 32'd0);
        synced = 1'b0;
        tick();
        run_div(32'd64_000_000, 16'd1, 29, "t5resync");

        // Asynchronous reset mid-division
        run_div(32'd16_000, 16'd4000, 29, "t5pre");
        trigger = 1'b1;
        rpm_sum = 32'd32_000;
        tick();
        trigger = 1'b0;
        repeat (10) tick();
        check("t5_busy_mid", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_arst_rpm", 32'(rpm), 32'd0);
        check("t5_arst_busy", 32'(busy), 32'd0);
        check("t5_arst_valid", 32'(rpm_valid), 32'd0);
        check("t5_arst_stalled", 32'(stalled), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Stall detection and recovery
        synced  = 1'b1;
        trigger = 1'b1;
        rpm_sum = 32'd16_000;
        tick();
        trigger = 1'b0;
        c = 1;
        while (!stalled && c < STALL + 50) begin
            tick();
            c++;
        end
        check("t6_stall_edge", 32'(c), 32'(STALL + 1));
        check("t6_stall_rpm", 32'(rpm), 32'd0);
        trigger = 1'b1;
        rpm_sum = 32'd32_000;
        tick();
        trigger = 1'b0;
        check("t6_stalled_busy", 32'(stalled), 32'd1);
        wait_valid(n);
        check("t6_lat", 32'(n + 1), 32'd29);
        check("t6_rpm", 32'(rpm), 32'd2000);
        check("t6_stall_clr", 32'(stalled), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
